// File: rtl/main_memory_arbiter_pkg.sv
// main_memory_arbiter_pkg: shared state encoding and requester port indices for the main memory arbiter.
package main_memory_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_BUSY = BUSY;
    localparam logic [1:0] S_RESP = RESP;

    localparam int PORT_CTRL = 0;
    localparam int PORT_DBG  = 1;

endpackage

// File: rtl/main_memory_arbiter_rr.sv
// main_memory_arbiter_rr: two-way round-robin select; on a tie the port that did not win last is granted.
module main_memory_arbiter_rr
    import main_memory_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    assign gnt[PORT_CTRL] = req[PORT_CTRL] & (~req[PORT_DBG] | last);
    assign gnt[PORT_DBG]  = req[PORT_DBG] & (~req[PORT_CTRL] | ~last);

endmodule

// File: rtl/main_memory_arbiter.sv
// main_memory_arbiter: round-robin sharing of MAIN_MEMORY between CONTROL (port 0) and the debug loader (port 1).
// Define MAIN_MEMORY_ARBITER_TIMEOUT_EN to abandon accesses after TIMEOUT_CYCLES BUSY cycles without ACK.
module main_memory_arbiter
    import main_memory_arbiter_pkg::*;
#(
    parameter int DATAWIDTH_BUS  = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                     MAIN_MEMORY_ARBITER_CLOCK_50,
    input  logic                     MAIN_MEMORY_ARBITER_ResetInLow_In,
    input  logic                     MAIN_MEMORY_ARBITER_Req0_In,
    input  logic                     MAIN_MEMORY_ARBITER_Req1_In,
    input  logic                     MAIN_MEMORY_ARBITER_WR0_In,
    input  logic                     MAIN_MEMORY_ARBITER_WR1_In,
    input  logic [DATAWIDTH_BUS-1:0] MAIN_MEMORY_ARBITER_Addr0_InBus,
    input  logic [DATAWIDTH_BUS-1:0] MAIN_MEMORY_ARBITER_Addr1_InBus,
    input  logic [DATAWIDTH_BUS-1:0] MAIN_MEMORY_ARBITER_WData0_InBus,
    input  logic [DATAWIDTH_BUS-1:0] MAIN_MEMORY_ARBITER_WData1_InBus,
    output logic                     MAIN_MEMORY_ARBITER_Ack0_Out,
    output logic                     MAIN_MEMORY_ARBITER_Ack1_Out,
    output logic                     MAIN_MEMORY_ARBITER_Err0_Out,
    output logic                     MAIN_MEMORY_ARBITER_Err1_Out,
    output logic [DATAWIDTH_BUS-1:0] MAIN_MEMORY_ARBITER_RData_OutBus,
    output logic [1:0]               MAIN_MEMORY_ARBITER_Grant_OutBus,
    output logic                     MAIN_MEMORY_ARBITER_RD_Out,
    output logic                     MAIN_MEMORY_ARBITER_WRMain_Out,
    output logic [DATAWIDTH_BUS-1:0] MAIN_MEMORY_ARBITER_A_OutBus,
    output logic [DATAWIDTH_BUS-1:0] MAIN_MEMORY_ARBITER_B_OutBus,
    input  logic                     MAIN_MEMORY_ARBITER_ACK_In,
    input  logic [DATAWIDTH_BUS-1:0] MAIN_MEMORY_ARBITER_Data_InBus
);

    logic [1:0]               state;
    logic                     last;
    logic [1:0]               req;
    logic [1:0]               gnt;
    logic                     sel_wr;
    logic [DATAWIDTH_BUS-1:0] sel_addr;
    logic [DATAWIDTH_BUS-1:0] sel_wdata;
    logic                     expire;

    assign req = {MAIN_MEMORY_ARBITER_Req1_In, MAIN_MEMORY_ARBITER_Req0_In};

    main_memory_arbiter_rr u_rr (
        .req  (req),
        .last (last),
        .gnt  (gnt)
    );

    assign sel_wr    = gnt[PORT_DBG] ? MAIN_MEMORY_ARBITER_WR1_In : MAIN_MEMORY_ARBITER_WR0_In;
    assign sel_addr  = gnt[PORT_DBG] ? MAIN_MEMORY_ARBITER_Addr1_InBus : MAIN_MEMORY_ARBITER_Addr0_InBus;
    assign sel_wdata = gnt[PORT_DBG] ? MAIN_MEMORY_ARBITER_WData1_InBus : MAIN_MEMORY_ARBITER_WData0_InBus;

`ifdef MAIN_MEMORY_ARBITER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CW-1:0] cnt;

    // cnt holds the number of BUSY cycles already elapsed without ACK
    always_ff @(posedge MAIN_MEMORY_ARBITER_CLOCK_50 or negedge MAIN_MEMORY_ARBITER_ResetInLow_In)
        if (!MAIN_MEMORY_ARBITER_ResetInLow_In)
            cnt <= '0;
        else if (state != S_BUSY)
            cnt <= '0;
        else if (!MAIN_MEMORY_ARBITER_ACK_In)
            cnt <= cnt + CW'(1);

    assign expire = (state == S_BUSY) && (cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT_CYCLES;
    assign expire = 1'b0;
`endif

    always_ff @(posedge MAIN_MEMORY_ARBITER_CLOCK_50 or negedge MAIN_MEMORY_ARBITER_ResetInLow_In) begin
        if (!MAIN_MEMORY_ARBITER_ResetInLow_In) begin
            state                            <= S_IDLE;
            last                             <= 1'b1;
            MAIN_MEMORY_ARBITER_Grant_OutBus <= '0;
            MAIN_MEMORY_ARBITER_RD_Out       <= 1'b0;
            MAIN_MEMORY_ARBITER_WRMain_Out   <= 1'b0;
            MAIN_MEMORY_ARBITER_A_OutBus     <= '0;
            MAIN_MEMORY_ARBITER_B_OutBus     <= '0;
            MAIN_MEMORY_ARBITER_RData_OutBus <= '0;
            MAIN_MEMORY_ARBITER_Ack0_Out     <= 1'b0;
            MAIN_MEMORY_ARBITER_Ack1_Out     <= 1'b0;
            MAIN_MEMORY_ARBITER_Err0_Out     <= 1'b0;
            MAIN_MEMORY_ARBITER_Err1_Out     <= 1'b0;
        end else begin
            MAIN_MEMORY_ARBITER_Ack0_Out <= 1'b0;
            MAIN_MEMORY_ARBITER_Ack1_Out <= 1'b0;
            MAIN_MEMORY_ARBITER_Err0_Out <= 1'b0;
            MAIN_MEMORY_ARBITER_Err1_Out <= 1'b0;
            case (state)
                S_IDLE: if (|req) begin
                    state                            <= S_BUSY;
                    last                             <= gnt[PORT_DBG];
                    MAIN_MEMORY_ARBITER_Grant_OutBus <= gnt;
                    MAIN_MEMORY_ARBITER_RD_Out       <= ~sel_wr;
                    MAIN_MEMORY_ARBITER_WRMain_Out   <= sel_wr;
                    MAIN_MEMORY_ARBITER_A_OutBus     <= sel_addr;
                    MAIN_MEMORY_ARBITER_B_OutBus     <= sel_wdata;
                    MAIN_MEMORY_ARBITER_RData_OutBus <= '0;
                end
                // a real ACK takes priority over a simultaneous timeout
                S_BUSY: if (MAIN_MEMORY_ARBITER_ACK_In || expire) begin
                    state                            <= S_RESP;
                    MAIN_MEMORY_ARBITER_RD_Out       <= 1'b0;
                    MAIN_MEMORY_ARBITER_WRMain_Out   <= 1'b0;
                    MAIN_MEMORY_ARBITER_RData_OutBus <= (MAIN_MEMORY_ARBITER_ACK_In && MAIN_MEMORY_ARBITER_RD_Out) ?
                                                        MAIN_MEMORY_ARBITER_Data_InBus : '0;
                    MAIN_MEMORY_ARBITER_Ack0_Out     <= MAIN_MEMORY_ARBITER_Grant_OutBus[PORT_CTRL];
                    MAIN_MEMORY_ARBITER_Ack1_Out     <= MAIN_MEMORY_ARBITER_Grant_OutBus[PORT_DBG];
                    MAIN_MEMORY_ARBITER_Err0_Out     <= ~MAIN_MEMORY_ARBITER_ACK_In & MAIN_MEMORY_ARBITER_Grant_OutBus[PORT_CTRL];
                    MAIN_MEMORY_ARBITER_Err1_Out     <= ~MAIN_MEMORY_ARBITER_ACK_In & MAIN_MEMORY_ARBITER_Grant_OutBus[PORT_DBG];
                end
                S_RESP: begin
                    state                            <= S_IDLE;
                    MAIN_MEMORY_ARBITER_Grant_OutBus <= '0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_main_memory_arbiter.sv
// tb_main_memory_arbiter: directed stimulus with a transaction-level reference model checked every cycle.
module tb_main_memory_arbiter;

    localparam int W  = 32;
    localparam int TO = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0 = 1'b0, req1 = 1'b0, wr0 = 1'b0, wr1 = 1'b0;
    logic [W-1:0] addr0 = '0, addr1 = '0, wd0 = '0, wd1 = '0;
    logic         ack0, ack1, err0, err1, rd, wrm;
    logic [W-1:0] rdata, a_bus, b_bus;
    logic [1:0]   grant;
    logic         resp_ack = 1'b0, stray_ack = 1'b0, mem_ack;
    logic [W-1:0] mem_data = '0;
    int           ack_delay = -1;
    int           strobe_cnt = 0;
    int           tests = 0, fails = 0;

    assign mem_ack = resp_ack | stray_ack;

    always #5 clk = ~clk;

    main_memory_arbiter #(.DATAWIDTH_BUS(W), .TIMEOUT_CYCLES(TO)) dut (
        .MAIN_MEMORY_ARBITER_CLOCK_50     (clk),
        .MAIN_MEMORY_ARBITER_ResetInLow_In(rst_n),
        .MAIN_MEMORY_ARBITER_Req0_In      (req0),
        .MAIN_MEMORY_ARBITER_Req1_In      (req1),
        .MAIN_MEMORY_ARBITER_WR0_In       (wr0),
        .MAIN_MEMORY_ARBITER_WR1_In       (wr1),
        .MAIN_MEMORY_ARBITER_Addr0_InBus  (addr0),
        .MAIN_MEMORY_ARBITER_Addr1_InBus  (addr1),
        .MAIN_MEMORY_ARBITER_WData0_InBus (wd0),
        .MAIN_MEMORY_ARBITER_WData1_InBus (wd1),
        .MAIN_MEMORY_ARBITER_Ack0_Out     (ack0),
        .MAIN_MEMORY_ARBITER_Ack1_Out     (ack1),
        .MAIN_MEMORY_ARBITER_Err0_Out     (err0),
        .MAIN_MEMORY_ARBITER_Err1_Out     (err1),
        .MAIN_MEMORY_ARBITER_RData_OutBus (rdata),
        .MAIN_MEMORY_ARBITER_Grant_OutBus (grant),
        .MAIN_MEMORY_ARBITER_RD_Out       (rd),
        .MAIN_MEMORY_ARBITER_WRMain_Out   (wrm),
        .MAIN_MEMORY_ARBITER_A_OutBus     (a_bus),
        .MAIN_MEMORY_ARBITER_B_OutBus     (b_bus),
        .MAIN_MEMORY_ARBITER_ACK_In       (mem_ack),
        .MAIN_MEMORY_ARBITER_Data_InBus   (mem_data)
    );

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_ack(input int p, input string name);
        int n;
        n = 0;
        while (!(p == 1 ? ack1 : ack0) && n < 20) begin
            cyc();
            n++;
        end
        chk(name, {31'd0, (p == 1 ? ack1 : ack0)}, 1);
    endtask

    // Memory: ACK once the strobe has been high for ack_delay cycles; data is a function of the address
    always @(posedge clk) begin
        #2;
        if (rd || wrm) begin
            strobe_cnt++;
            resp_ack = (strobe_cnt == ack_delay);
        end else begin
            strobe_cnt = 0;
            resp_ack   = 1'b0;
        end
        mem_data = a_bus ^ 32'h5A5A_0000;
    end

    // Reference model: one in-flight transaction record, owner < 0 means nobody holds the memory
    int           m_owner = -1, m_last = 1, m_wait = 0;
    bit           m_resp = 0, m_wr = 0;
    logic [W-1:0] m_a = '0, m_b = '0, m_rdata = '0;
    logic [1:0]   m_ack = '0, m_err = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner = -1; m_last = 1; m_wait = 0; m_resp = 0; m_wr = 0;
            m_a = '0; m_b = '0; m_rdata = '0; m_ack = '0; m_err = '0;
        end else begin
            m_ack = '0;
            m_err = '0;
            if (m_resp) begin
                m_resp  = 0;
                m_owner = -1;
            end else if (m_owner < 0) begin
                if (req0 || req1) begin
                    m_owner = (req0 && req1) ? 1 - m_last : (req1 ? 1 : 0);
                    m_last  = m_owner;
                    m_wr    = (m_owner == 1) ? wr1 : wr0;
                    m_a     = (m_owner == 1) ? addr1 : addr0;
                    m_b     = (m_owner == 1) ? wd1 : wd0;
                    m_rdata = '0;
                    m_wait  = 0;
                end
            end else begin
                m_wait++;
                if (mem_ack) begin
                    m_rdata        = m_wr ? '0 : mem_data;
                    m_resp         = 1;
                    m_ack[m_owner] = 1'b1;
                end
`ifdef MAIN_MEMORY_ARBITER_TIMEOUT_EN
                else if (m_wait == TO) begin
                    m_rdata        = '0;
                    m_resp         = 1;
                    m_ack[m_owner] = 1'b1;
                    m_err[m_owner] = 1'b1;
                end
`endif
            end
        end
    end

    always @(negedge clk) begin : cmp
        logic       e_busy;
        logic [1:0] e_grant;
        e_busy  = (m_owner >= 0) && !m_resp;
        e_grant = (m_owner < 0) ? 2'b00 : (m_owner == 1 ? 2'b10 : 2'b01);
        chk("ctrl{rd,wr,grant,ack0,ack1,err0,err1}", {24'd0, rd, wrm, grant, ack0, ack1, err0, err1},
            {24'd0, e_busy && !m_wr, e_busy && m_wr, e_grant, m_ack[0], m_ack[1], m_err[0], m_err[1]});
        chk("A", a_bus, m_a);
        chk("B", b_bus, m_b);
        chk("RData", rdata, m_rdata);
    end

    int q[$];
    int c0, c1, rd_cnt, err_seen;

    initial begin
        repeat (2) cyc();
        chk("reset ctrl", {24'd0, rd, wrm, grant, ack0, ack1, err0, err1}, 0);
        chk("reset A", a_bus, 0);
        rst_n = 1'b1;
        cyc();

        // Read on port 0, memory ACK 3 cycles after RD
        req0 = 1; wr0 = 0; addr0 = 32'h10; wd0 = 32'h1111; ack_delay = 3;
        cyc();
        chk("t1 c1 {rd,grant}", {29'd0, rd, grant}, 3'b101);
        chk("t1 c1 A", a_bus, 32'h10);
        cyc(); cyc();
        chk("t1 c3 rd", {31'd0, rd}, 1);
        cyc();
        chk("t1 c4 {ack0,rd,grant}", {28'd0, ack0, rd, grant}, 4'b1001);
        chk("t1 c4 rdata", rdata, 32'h5A5A_0010);
        req0 = 0;
        cyc();
        chk("t1 c5 {ack0,grant}", {29'd0, ack0, grant}, 0);
        stray_ack = 1;
        cyc();
        stray_ack = 0;
        chk("stray ack ignored", {28'd0, rd, wrm, grant}, 0);

        // Write on port 1
        req1 = 1; wr1 = 1; addr1 = 32'h20; wd1 = 32'hDEAD_BEEF; ack_delay = 2;
        cyc();
        chk("t2 c1 {wrm,rd,grant}", {28'd0, wrm, rd, grant}, 4'b1010);
        chk("t2 c1 B", b_bus, 32'hDEAD_BEEF);
        cyc();
        chk("t2 c2 A", a_bus, 32'h20);
        cyc();
        chk("t2 c3 {ack1,wrm}", {30'd0, ack1, wrm}, 2'b10);
        chk("t2 c3 rdata", rdata, 0);
        req1 = 0;
        cyc();

        // Request withdrawn mid-transaction still completes
        req0 = 1; addr0 = 32'h30; ack_delay = 3;
        cyc(); cyc();
        req0 = 0;
        wait_ack(0, "t2b dropped req acked");
        repeat (2) cyc();

        // Both ports requesting continuously from reset
        rst_n = 0; req0 = 1; req1 = 1; wr0 = 0; wr1 = 0; addr0 = 32'h100; addr1 = 32'h200;
        cyc();
        rst_n = 1; ack_delay = 1; c0 = 0; c1 = 0;
        repeat (40) begin
            cyc();
            if (ack0) begin q.push_back(0); c0++; addr0 += 4; end
            if (ack1) begin q.push_back(1); c1++; addr1 += 4; end
        end
        req0 = 0; req1 = 0;
        chk("t3 count", {31'd0, q.size() >= 8}, 1);
        if (q.size() >= 4) chk("t3 order", {28'd0, q[0][0], q[1][0], q[2][0], q[3][0]}, 4'b0101);
        chk("t3 balance", {31'd0, (c0 - c1 <= 1) && (c1 - c0 <= 1)}, 1);
        repeat (6) cyc();

        // Reset in the middle of a BUSY access
        req0 = 1; addr0 = 32'h40; ack_delay = -1;
        cyc(); cyc();
        chk("t4 busy", {31'd0, rd}, 1);
        rst_n = 0;
        #1;
        chk("t4 reset ctrl", {24'd0, rd, wrm, grant, ack0, ack1, err0, err1}, 0);
        chk("t4 reset A", a_bus, 0);
        cyc();
        rst_n = 1; ack_delay = 2;
        wait_ack(0, "t4 served after reset");
        chk("t4 rdata", rdata, 32'h5A5A_0040);
        req0 = 0;
        repeat (2) cyc();

        // Memory never answers
        req0 = 1; addr0 = 32'h50; ack_delay = -1;
`ifdef MAIN_MEMORY_ARBITER_TIMEOUT_EN
        rd_cnt = 0;
        repeat (TO) begin
            cyc();
            if (rd) rd_cnt++;
        end
        chk("t5 rd cycles", rd_cnt, TO);
        cyc();
        chk("t5 {ack0,err0,rd}", {29'd0, ack0, err0, rd}, 3'b110);
        chk("t5 rdata", rdata, 0);
        req0 = 0;
`else
        rd_cnt = 0; err_seen = 0;
        repeat (100) begin
            cyc();
            if (rd) rd_cnt++;
            if (err0) err_seen++;
        end
        chk("t5 rd held", rd_cnt, 100);
        chk("t5 no err", err_seen, 0);
        stray_ack = 1;
        cyc();
        stray_ack = 0;
        chk("t5 late ack", {30'd0, ack0, err0}, 2'b10);
        chk("t5 rdata", rdata, 32'h5A5A_0050);
        req0 = 0;
`endif
        repeat (3) cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
